// File: rtl/pri_decode38.sv
// Sequential 3-to-8 decoder with mask accumulator: ORs one-hot decodes of a
// serialized {idc, code} stream and presents the rebuilt mask per group.
module pri_decode38 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_idc,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_mask,
    output logic [7:0] out_onehot,
    output logic [3:0] out_count,
    output logic       out_dup
);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic       dup_q, dup_d;
    logic [7:0] out_mask_q, out_mask_d;
    logic [7:0] out_onehot_q, out_onehot_d;
    logic [3:0] out_count_q, out_count_d;
    logic       out_dup_q, out_dup_d;

    logic [7:0] onehot_s;
    logic [7:0] new_mask_s;
    logic       new_dup_s;
    logic       accept_s;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Handshake signals depend only on state and en, never on in_valid.
    always_comb begin
        in_ready  = (state_q == ST_ACC) && en;
        out_valid = (state_q == ST_OUT);
        accept_s  = in_valid && in_ready;
    end

    // Decode of the current beat and its effect on the accumulators.
    always_comb begin
        if (in_idc) begin
            onehot_s = 8'h01 << in_code;
        end else begin
            onehot_s = 8'h00;
        end
        new_mask_s = mask_q | onehot_s;
        new_dup_s  = dup_q | (|(mask_q & onehot_s));
    end

    // Next-state and result-capture logic.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        dup_d        = dup_q;
        out_mask_d   = out_mask_q;
        out_onehot_d = out_onehot_q;
        out_count_d  = out_count_q;
        out_dup_d    = out_dup_q;
        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
                    mask_d = new_mask_s;
                    dup_d  = new_dup_s;
                    if (in_last) begin
                        out_mask_d   = new_mask_s;
                        out_onehot_d = onehot_s;
                        out_count_d  = popcount8(new_mask_s);
                        out_dup_d    = new_dup_s;
                        state_d      = ST_OUT;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                // Result stays frozen until consumed; accumulators clear on handshake.
                if (out_ready) begin
                    mask_d  = 8'h00;
                    dup_d   = 1'b0;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_ACC;
                mask_d  = 8'h00;
                dup_d   = 1'b0;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACC;
            mask_q       <= 8'h00;
            dup_q        <= 1'b0;
            out_mask_q   <= 8'h00;
            out_onehot_q <= 8'h00;
            out_count_q  <= 4'd0;
            out_dup_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            dup_q        <= dup_d;
            out_mask_q   <= out_mask_d;
            out_onehot_q <= out_onehot_d;
            out_count_q  <= out_count_d;
            out_dup_q    <= out_dup_d;
        end
    end

    assign out_mask   = out_mask_q;
    assign out_onehot = out_onehot_q;
    assign out_count  = out_count_q;
    assign out_dup    = out_dup_q;

endmodule

// File: tb/tb_pri_decode38.sv
// Scoreboard bench for pri_decode38: directed groups push hand-computed results,
// a monitor pops and compares on every output handshake.
module tb_pri_decode38;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_idc;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_mask;
    logic [7:0] out_onehot;
    logic [3:0] out_count;
    logic       out_dup;

    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] oh;
        logic [3:0] cnt;
        logic       dup;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    pri_decode38 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_idc     (in_idc),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_onehot (out_onehot),
        .out_count  (out_count),
        .out_dup    (out_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] code, input logic idc, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        in_idc   = idc;
        in_last  = last;
        for (int i = 0; i < 64 && !done; i++) begin
            #1 done = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic push(input logic [7:0] m, input logic [7:0] oh, input logic [3:0] c, input logic d);
        exp_t e;
        e.mask = m; e.oh = oh; e.cnt = c; e.dup = d;
        sb.push_back(e);
    endtask

    task automatic drain;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            #2 done = (sb.size() == 0) && !out_valid;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got pending %0d expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    // Monitor: a result is consumed on the edge after a valid&&ready sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got mask %0h expected no output", out_mask);
                end else begin
                    e = sb.pop_front();
                    chk("out_mask", {24'd0, out_mask}, {24'd0, e.mask});
                    chk("out_onehot", {24'd0, out_onehot}, {24'd0, e.oh});
                    chk("out_count", {28'd0, out_count}, {28'd0, e.cnt});
                    chk("out_dup", {31'd0, out_dup}, {31'd0, e.dup});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_code = 3'd0;
        in_idc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_mask", {24'd0, out_mask}, 32'd0);
        chk("rst_out_onehot", {24'd0, out_onehot}, 32'd0);
        chk("rst_out_count", {28'd0, out_count}, 32'd0);
        chk("rst_out_dup", {31'd0, out_dup}, 32'd0);
        chk("rst_in_ready_en0", {31'd0, in_ready}, 32'd0);
        en = 1'b1;
        #1 chk("rst_in_ready_en1", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat; output visible the cycle after accept.
        push(8'h20, 8'h20, 4'd1, 1'b0);
        send(3'd5, 1'b1, 1'b1);
        #1 chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("out_in_ready", {31'd0, in_ready}, 32'd0);
        drain();

        push(8'h89, 8'h80, 4'd3, 1'b0);
        send(3'd0, 1'b1, 1'b0); send(3'd3, 1'b1, 1'b0); send(3'd7, 1'b1, 1'b1);
        push(8'h02, 8'h02, 4'd1, 1'b0);
        send(3'd1, 1'b1, 1'b1);
        drain();

        push(8'h14, 8'h10, 4'd2, 1'b1);
        send(3'd2, 1'b1, 1'b0); send(3'd2, 1'b1, 1'b0); send(3'd4, 1'b1, 1'b1);
        drain();

        push(8'h02, 8'h00, 4'd1, 1'b0);
        send(3'd1, 1'b1, 1'b0); send(3'd6, 1'b0, 1'b1);
        drain();

        push(8'hFF, 8'h80, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) send(i[2:0], 1'b1, (i == 7));
        drain();

        push(8'h00, 8'h00, 4'd0, 1'b0);
        send(3'd3, 1'b0, 1'b1);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        push(8'h40, 8'h40, 4'd1, 1'b0);
        send(3'd6, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_mask", {24'd0, out_mask}, 32'h40);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // Enable low blocks acceptance; accumulator resumes afterwards.
        push(8'h21, 8'h20, 4'd2, 1'b0);
        send(3'd0, 1'b1, 1'b0);
        en = 1'b0;
        in_valid = 1'b1; in_code = 3'd5; in_idc = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("en0_in_ready", {31'd0, in_ready}, 32'd0);
            chk("en0_out_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        en = 1'b1;
        send(3'd5, 1'b1, 1'b1);
        drain();

        // Reset mid-group discards the partial mask.
        send(3'd1, 1'b1, 1'b0); send(3'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1 chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(8'h08, 8'h08, 4'd1, 1'b0);
        send(3'd3, 1'b1, 1'b1);
        drain();

        // Reset while in OUT drops the pending result at once.
        out_ready = 1'b0;
        send(3'd4, 1'b1, 1'b1);
        #1 chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("outrst_valid", {31'd0, out_valid}, 32'd0);
        chk("outrst_mask", {24'd0, out_mask}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        push(8'h80, 8'h80, 4'd1, 1'b0);
        send(3'd7, 1'b1, 1'b1);
        drain();

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pri_decode38.md
# pri_decode38

Sequential 3-to-8 decoder and mask accumulator. It consumes the `{idc, y}` code stream produced by the 8-to-3 priority encoder, one code per handshake, and ORs each decoded one-hot into an 8-bit mask. On a beat flagged `in_last` it presents the rebuilt mask, the final beat's one-hot, a population count and a duplicate flag behind a valid/ready output stage. It sits downstream of the encoder on the request path and rebuilds request vectors from a serialized index stream.

## Interface
Parameters:
- none (widths fixed at 3-bit code / 8-bit mask)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  input enable; gates acceptance only
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready at clk rise
- in_code  in  3  encoded index (encoder `y`)
- in_idc  in  1  encoder "any bit set" flag; 0 means the beat decodes to 8'h00
- in_last  in  1  final beat of a group
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready at clk rise
- out_mask  out  8  OR of all one-hots in the group
- out_onehot  out  8  one-hot of the in_last beat
- out_count  out  4  number of set bits in out_mask (0..8)
- out_dup  out  1  some beat in the group decoded to a bit already set in the mask

## Operation
- State machine with two states, ACC (reset state) and OUT.
- In ACC:
  - in_ready = en; out_valid = 0.
  - On accept, form onehot = in_idc ? (8'b1 << in_code) : 8'h00.
  - Update mask_r <= mask_r | onehot.
  - Update dup_r <= dup_r | (|(mask_r & onehot)).
- Accepted beat with in_last = 1: register out_mask = mask_r | onehot, out_onehot = onehot, out_count = popcount of the new mask, and out_dup = updated dup; go to OUT.
- In OUT:
  - in_ready = 0; out_valid = 1; outputs are stable.
  - On out_ready: clear mask_r and dup_r to 0 and return to ACC.
- en = 0: no input accepted and accumulators hold. en has no effect in OUT, so the output handshake still completes.
- A group of a single beat is legal (in_last on the first beat).
- A beat with in_idc = 0 is a legal no-op contribution and still counts as a beat, including as a last beat.
- in_code is ignored when in_idc = 0.
- out_count is computed from the registered-in mask, never from a 3-bit index, and has a range of 0..8.

## Timing
- Reset values: state = ACC, mask_r = 0, dup_r = 0, out_valid = 0, out_mask = 0, out_onehot = 0, out_count = 0, out_dup = 0. in_ready follows en after reset.
- Latency: out_valid rises on the clock edge that accepts the in_last beat and is visible the following cycle.
- Throughput:
  - One input beat per cycle while in ACC.
  - in_ready is low for every cycle in OUT, so at least one bubble occurs per group, including when out_ready is tied high.
- Holding out_ready = 1 while in OUT completes the output handshake in 1 cycle; the next input can be accepted in the cycle after.
- out_valid never drops without a handshake.
- in_ready is combinational from state and en only, never from in_valid.
- Reset asserted mid-group or in OUT: all state clears immediately (asynchronous); a partial group is discarded.
- An in_valid/in_last beat presented during OUT is not accepted and must be held by the upstream.

## Test plan
- Reset then single beat: in_code = 5, in_idc = 1, in_last = 1 -> next cycle out_valid = 1, out_mask = 8'h20, out_onehot = 8'h20, out_count = 1, out_dup = 0.
- Group of codes 0, 3, 7 (last on 7), out_ready = 1 -> out_mask = 8'h89, out_onehot = 8'h80, out_count = 3, out_dup = 0. A following group of code 1 gives out_mask = 8'h02 (accumulator cleared).
- Duplicate group: codes 2, 2, 4 (last) -> out_mask = 8'h14, out_count = 2, out_dup = 1.
- in_idc = 0 beat with in_code = 6 as last, following code 1 -> out_mask = 8'h02, out_onehot = 8'h00, out_count = 1. All eight codes in one group -> out_mask = 8'hFF, out_count = 8.
- Backpressure and enable:
  - out_ready low 5 cycles -> outputs stable, in_ready = 0 throughout.
  - en = 0 in ACC with in_valid = 1 -> no accept and mask unchanged; en = 1 resumes from the held mask.
- rst_n pulsed low mid-group after codes 1 and 2, then group code 3 (last) -> out_mask = 8'h08, out_dup = 0. rst_n low during OUT -> out_valid = 0 immediately.
